// File: rtl/display_pkg.sv
// Shared types and constants for the display pixel unpacker.
// DISPLAY_RGB_OUT_EN selects the RGB converter pipeline depth.
package display_pkg;

  localparam int MB_X_BITS = 8;
  localparam int MB_Y_BITS = 8;

  localparam logic [7:0] BLACK_Y = 8'd16;
  localparam logic [7:0] BLACK_C = 8'd128;

  localparam logic signed [19:0] COEF_Y   = 20'sd298;
  localparam logic signed [19:0] COEF_RV  = 20'sd409;
  localparam logic signed [19:0] COEF_GU  = 20'sd100;
  localparam logic signed [19:0] COEF_GV  = 20'sd208;
  localparam logic signed [19:0] COEF_BU  = 20'sd516;
  localparam logic signed [19:0] COEF_RND = 20'sd128;

`ifdef DISPLAY_RGB_OUT_EN
  localparam int RGB_PIPE_DEPTH = 3;
`else
  localparam int RGB_PIPE_DEPTH = 0;
`endif

  typedef struct packed {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
  } pixel_t;

  // Rounded sum -> 8-bit channel, saturating at both ends.
  function automatic logic [7:0] clamp_u8(input logic signed [19:0] sum);
    logic signed [19:0] sh;
    sh = sum >>> 8;
    if (sh < 20'sd0) return 8'd0;
    if (sh > 20'sd255) return 8'hff;
    return sh[7:0];
  endfunction

endpackage

// File: rtl/display_pixel_unpack_ycbcr_to_rgb.sv
// Three-stage BT.601 YCbCr -> RGB converter: offset, multiply, sum/round/clamp.
// Fixed 3-cycle latency, no backpressure; outputs are zero when the pixel is not valid.
module ycbcr_to_rgb
  import display_pkg::*;
(
  input  logic   video_clk,
  input  logic   rst_n,
  input  pixel_t ycc,
  input  logic   in_de,
  output pixel_t rgb,
  output logic   out_de
);

  logic signed [19:0] s1_y, s1_cb, s1_cr;
  logic               s1_de;
  logic signed [19:0] s2_y, s2_rv, s2_gu, s2_gv, s2_bu;
  logic               s2_de;
  logic signed [19:0] r_sum, g_sum, b_sum;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_y  <= '0;
      s1_cb <= '0;
      s1_cr <= '0;
      s1_de <= 1'b0;
      s2_y  <= '0;
      s2_rv <= '0;
      s2_gu <= '0;
      s2_gv <= '0;
      s2_bu <= '0;
      s2_de <= 1'b0;
      rgb   <= '0;
      out_de <= 1'b0;
    end else begin
      s1_y  <= $signed({12'd0, ycc.c0}) - 20'sd16;
      s1_cb <= $signed({12'd0, ycc.c1}) - 20'sd128;
      s1_cr <= $signed({12'd0, ycc.c2}) - 20'sd128;
      s1_de <= in_de;

      s2_y  <= s1_y * COEF_Y;
      s2_rv <= s1_cr * COEF_RV;
      s2_gu <= s1_cb * COEF_GU;
      s2_gv <= s1_cr * COEF_GV;
      s2_bu <= s1_cb * COEF_BU;
      s2_de <= s1_de;

      out_de <= s2_de;
      if (s2_de) begin
        rgb.c0 <= clamp_u8(r_sum);
        rgb.c1 <= clamp_u8(g_sum);
        rgb.c2 <= clamp_u8(b_sum);
      end else begin
        rgb <= '0;
      end
    end
  end

  always_comb begin
    r_sum = s2_y + s2_rv + COEF_RND;
    g_sum = s2_y - s2_gu - s2_gv + COEF_RND;
    b_sum = s2_y + s2_bu + COEF_RND;
  end

endmodule

// File: rtl/display_pixel_unpack.sv
// Serialises 64-bit luma/chroma words into one pixel per video_clk, blacks out-of-picture pixels.
// Latency 2 cycles (5 with DISPLAY_RGB_OUT_EN); no backpressure, syncs delayed to match.
module display_pixel_unpack
  import display_pkg::*;
#(
  parameter logic [7:0] PIC_BLACK_Y = BLACK_Y,
  parameter logic [7:0] PIC_BLACK_C = BLACK_C
) (
  input  logic                 video_clk,
  input  logic                 rst_n,
  input  logic                 video_is_next_pixel_active,
  input  logic [12:0]          video_next_x,
  input  logic [12:0]          video_y,
  input  logic                 video_hs_n,
  input  logic                 video_vs_n,
  input  logic [MB_X_BITS:0]   pic_width_in_mbs,
  input  logic [MB_Y_BITS:0]   pic_height_in_map_units,
  input  logic [63:0]          y_data,
  input  logic [63:0]          u_data,
  input  logic [63:0]          v_data,
  output logic [7:0]           pix_c0,
  output logic [7:0]           pix_c1,
  output logic [7:0]           pix_c2,
  output logic                 out_de,
  output logic                 out_hs_n,
  output logic                 out_vs_n
);

  localparam int SYNC_DEPTH = 1 + RGB_PIPE_DEPTH;

  logic [12:0] cur_x;
  logic        cur_act;
  logic [63:0] y_word, u_word, v_word;
  logic [12:0] pic_w_px, pic_h_px;
  logic        in_pic;
  pixel_t      b_pix_nxt, b_pix, final_pix;
  logic        b_de, final_de;
  logic [SYNC_DEPTH-1:0] hs_pipe, vs_pipe;

  // Stage A: capture position and word groups for the pixel presented next cycle.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x   <= '0;
      cur_act <= 1'b0;
      y_word  <= '0;
      u_word  <= '0;
      v_word  <= '0;
    end else begin
      cur_act <= video_is_next_pixel_active;
      if (video_is_next_pixel_active) begin
        cur_x <= video_next_x;
        if (video_next_x[2:0] == 3'd0) y_word <= y_data;
        if (video_next_x[3:0] == 4'd0) begin
          u_word <= u_data;
          v_word <= v_data;
        end
      end
    end
  end

  assign pic_w_px = {pic_width_in_mbs, 4'b0000};
  assign pic_h_px = {pic_height_in_map_units, 4'b0000};
  assign in_pic   = (cur_x < pic_w_px) && (video_y < pic_h_px);

  // Chroma is indexed at half rate: each Cb/Cr byte covers two adjacent pixels.
  always_comb begin
    b_pix_nxt = '0;
    if (cur_act) begin
      if (in_pic) begin
        b_pix_nxt.c0 = y_word[{cur_x[2:0], 3'b000} +: 8];
        b_pix_nxt.c1 = u_word[{cur_x[3:1], 3'b000} +: 8];
        b_pix_nxt.c2 = v_word[{cur_x[3:1], 3'b000} +: 8];
      end else begin
        b_pix_nxt.c0 = PIC_BLACK_Y;
        b_pix_nxt.c1 = PIC_BLACK_C;
        b_pix_nxt.c2 = PIC_BLACK_C;
      end
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      b_pix <= '0;
      b_de  <= 1'b0;
    end else begin
      b_pix <= b_pix_nxt;
      b_de  <= cur_act;
    end
  end

  // Syncs already refer to the current pixel, so they need one stage less than the data.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      hs_pipe[0] <= video_hs_n;
      vs_pipe[0] <= video_vs_n;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

`ifdef DISPLAY_RGB_OUT_EN
  ycbcr_to_rgb u_csc (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .ycc       (b_pix),
    .in_de     (b_de),
    .rgb       (final_pix),
    .out_de    (final_de)
  );
`else
  assign final_pix = b_pix;
  assign final_de  = b_de;
`endif

  assign pix_c0   = final_pix.c0;
  assign pix_c1   = final_pix.c1;
  assign pix_c2   = final_pix.c2;
  assign out_de   = final_de;
  assign out_hs_n = hs_pipe[SYNC_DEPTH-1];
  assign out_vs_n = vs_pipe[SYNC_DEPTH-1];

endmodule

// File: tb/tb_display_pixel_unpack.sv
// Bench for display_pixel_unpack: directed tables plus random lines against a reference model.
`timescale 1ns/1ps
module tb_display_pixel_unpack;
  import display_pkg::*;

  localparam int D = RGB_PIPE_DEPTH;

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_is_next_pixel_active = 1'b0;
  logic [12:0] video_next_x = '0;
  logic [12:0] video_y = '0;
  logic        video_hs_n = 1'b1;
  logic        video_vs_n = 1'b1;
  logic [MB_X_BITS:0] pic_width_in_mbs = 1;
  logic [MB_Y_BITS:0] pic_height_in_map_units = 1;
  logic [63:0] y_data = '0, u_data = '0, v_data = '0;
  logic [7:0]  pix_c0, pix_c1, pix_c2;
  logic        out_de, out_hs_n, out_vs_n;

  display_pixel_unpack dut (
    .video_clk(video_clk), .rst_n(rst_n),
    .video_is_next_pixel_active(video_is_next_pixel_active),
    .video_next_x(video_next_x), .video_y(video_y),
    .video_hs_n(video_hs_n), .video_vs_n(video_vs_n),
    .pic_width_in_mbs(pic_width_in_mbs), .pic_height_in_map_units(pic_height_in_map_units),
    .y_data(y_data), .u_data(u_data), .v_data(v_data),
    .pix_c0(pix_c0), .pix_c1(pix_c1), .pix_c2(pix_c2),
    .out_de(out_de), .out_hs_n(out_hs_n), .out_vs_n(out_vs_n)
  );

  always #5 video_clk = ~video_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cap_c0[$], cap_c1[$], cap_c2[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Pixel state: most recent captured word of each kind and the pixel being shown.
  int m_act, m_x;
  logic [63:0] m_y, m_u, m_v;
  // Output history of the YCbCr stage, newest at index 0.
  int h_de[8], h_c0[8], h_c1[8], h_c2[8], h_hs[8], h_vs[8];

  function automatic int byte_of(input logic [63:0] w, input int n);
    return int'((w >> (8 * n)) & 64'hff);
  endfunction

  function automatic int clamp255(input int s);
    int v;
    if (s < 0) return 0;
    v = s >>> 8;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int ref_r(input int y, input int cb, input int cr);
    return clamp255(298 * (y - 16) + 409 * (cr - 128) + 128);
  endfunction
  function automatic int ref_g(input int y, input int cb, input int cr);
    return clamp255(298 * (y - 16) - 100 * (cb - 128) - 208 * (cr - 128) + 128);
  endfunction
  function automatic int ref_b(input int y, input int cb, input int cr);
    return clamp255(298 * (y - 16) + 516 * (cb - 128) + 128);
  endfunction

  task automatic model_reset();
    m_act = 0; m_x = 0; m_y = '0; m_u = '0; m_v = '0;
    for (int i = 0; i < 8; i++) begin
      h_de[i] = 0; h_c0[i] = 0; h_c1[i] = 0; h_c2[i] = 0; h_hs[i] = 1; h_vs[i] = 1;
    end
  endtask

  task automatic model_edge();
    int bde, b0, b1, b2;
    bit inp;
    inp = (m_x < int'(pic_width_in_mbs) * 16) && (int'(video_y) < int'(pic_height_in_map_units) * 16);
    bde = m_act; b0 = 0; b1 = 0; b2 = 0;
    if (m_act != 0) begin
      if (inp) begin
        b0 = byte_of(m_y, m_x % 8);
        b1 = byte_of(m_u, (m_x % 16) / 2);
        b2 = byte_of(m_v, (m_x % 16) / 2);
      end else begin
        b0 = 16; b1 = 128; b2 = 128;
      end
    end
    for (int i = 7; i > 0; i--) begin
      h_de[i] = h_de[i-1]; h_c0[i] = h_c0[i-1]; h_c1[i] = h_c1[i-1];
      h_c2[i] = h_c2[i-1]; h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
    end
    h_de[0] = bde; h_c0[0] = b0; h_c1[0] = b1; h_c2[0] = b2;
    h_hs[0] = int'(video_hs_n); h_vs[0] = int'(video_vs_n);
    if (video_is_next_pixel_active) begin
      m_act = 1;
      m_x = int'(video_next_x);
      if (m_x % 8 == 0) m_y = y_data;
      if (m_x % 16 == 0) begin m_u = u_data; m_v = v_data; end
    end else begin
      m_act = 0;
    end
  endtask

  task automatic check_model();
    int e0, e1, e2;
    e0 = h_c0[D]; e1 = h_c1[D]; e2 = h_c2[D];
`ifdef DISPLAY_RGB_OUT_EN
    if (h_de[D] != 0) begin
      e0 = ref_r(h_c0[D], h_c1[D], h_c2[D]);
      e1 = ref_g(h_c0[D], h_c1[D], h_c2[D]);
      e2 = ref_b(h_c0[D], h_c1[D], h_c2[D]);
    end else begin
      e0 = 0; e1 = 0; e2 = 0;
    end
`endif
    chk("model_de", int'(out_de), h_de[D]);
    chk("model_c0", int'(pix_c0), e0);
    chk("model_c1", int'(pix_c1), e1);
    chk("model_c2", int'(pix_c2), e2);
    chk("model_hs", int'(out_hs_n), h_hs[D]);
    chk("model_vs", int'(out_vs_n), h_vs[D]);
  endtask

  task automatic step();
    @(posedge video_clk);
    model_edge();
    cyc++;
    #1;
    check_model();
    if (out_de) begin
      cap_c0.push_back(int'(pix_c0));
      cap_c1.push_back(int'(pix_c1));
      cap_c2.push_back(int'(pix_c2));
    end
  endtask

  task automatic drive_px(input int act, input int x);
    video_is_next_pixel_active = (act != 0);
    video_next_x = 13'(x);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_px(0, int'(video_next_x));
  endtask

  task automatic clear_caps();
    cap_c0.delete(); cap_c1.delete(); cap_c2.delete();
  endtask

  typedef struct {
    int x;
    int exp_y;
    int exp_cb;
  } line_vec_t;

  typedef struct {
    int y, cb, cr;
    int r, g, b;
  } rgb_vec_t;

  line_vec_t tbl[16];
  rgb_vec_t  rtbl[4];

  initial begin
    int cyc0, first_de, fall, rise, nblack;
    int exp_k0, exp_k1, exp_k2;
    logic [7:0] b8;

    for (int i = 0; i < 16; i++) begin
      tbl[i].x = i; tbl[i].exp_y = i; tbl[i].exp_cb = 'h80 + i / 2;
    end
    rtbl[0] = '{235, 128, 128, 255, 255, 255};
    rtbl[1] = '{16, 128, 128, 0, 0, 0};
    rtbl[2] = '{81, 90, 240, 255, 0, 0};
    rtbl[3] = '{128, 128, 128, 130, 130, 130};

    model_reset();
    #12;
    chk("reset_de", int'(out_de), 0);
    chk("reset_c0", int'(pix_c0), 0);
    chk("reset_c1", int'(pix_c1), 0);
    chk("reset_c2", int'(pix_c2), 0);
    chk("reset_hs", int'(out_hs_n), 1);
    chk("reset_vs", int'(out_vs_n), 1);
    @(negedge video_clk);
    rst_n = 1'b1;
    idle(3);

    // Directed line: x = 0..15, word 0 then word 1 at the group boundary.
    pic_width_in_mbs = 1; pic_height_in_map_units = 1; video_y = 0;
    u_data = 64'h8786858483828180; v_data = 64'hc7c6c5c4c3c2c1c0;
    clear_caps();
    cyc0 = cyc; first_de = -1;
    for (int x = 0; x < 16; x++) begin
      y_data = (x < 8) ? 64'h0706050403020100 : 64'h0f0e0d0c0b0a0908;
      drive_px(1, x);
      if (out_de && first_de < 0) first_de = cyc;
    end
    for (int i = 0; i < D + 4; i++) begin
      drive_px(0, 15);
      if (out_de && first_de < 0) first_de = cyc;
    end
    chk("latency", first_de - cyc0, D + 2);
    chk("line_count", cap_c0.size(), 16);
`ifndef DISPLAY_RGB_OUT_EN
    for (int i = 0; i < 16; i++) begin
      if (i < cap_c0.size()) begin
        chk($sformatf("line_y[%0d]", tbl[i].x), cap_c0[i], tbl[i].exp_y);
        chk($sformatf("line_cb[%0d]", tbl[i].x), cap_c1[i], tbl[i].exp_cb);
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      b8 = rtbl[k].y[7:0];  y_data = {8{b8}};
      b8 = rtbl[k].cb[7:0]; u_data = {8{b8}};
      b8 = rtbl[k].cr[7:0]; v_data = {8{b8}};
      clear_caps();
      for (int x = 0; x < 16; x++) drive_px(1, x);
      idle(D + 4);
      chk($sformatf("rgb_count[%0d]", k), cap_c0.size(), 16);
      if (cap_c0.size() > 0) begin
        chk($sformatf("rgb_r[%0d]", k), cap_c0[0], rtbl[k].r);
        chk($sformatf("rgb_g[%0d]", k), cap_c1[0], rtbl[k].g);
        chk($sformatf("rgb_b[%0d]", k), cap_c2[0], rtbl[k].b);
      end
    end
`endif

`ifdef DISPLAY_RGB_OUT_EN
    exp_k0 = 0; exp_k1 = 0; exp_k2 = 0;
`else
    exp_k0 = 16; exp_k1 = 128; exp_k2 = 128;
`endif

    // 32-pixel line on a 1-MB-wide picture: right half must be black.
    clear_caps();
    for (int x = 0; x < 32; x++) begin
      y_data = {$urandom, $urandom}; u_data = {$urandom, $urandom}; v_data = {$urandom, $urandom};
      drive_px(1, x);
    end
    idle(D + 4);
    chk("wide_count", cap_c0.size(), 32);
    for (int i = 16; i < 32; i++) begin
      if (i < cap_c0.size()) begin
        chk($sformatf("wide_black_c0[%0d]", i), cap_c0[i], exp_k0);
        chk($sformatf("wide_black_c1[%0d]", i), cap_c1[i], exp_k1);
        chk($sformatf("wide_black_c2[%0d]", i), cap_c2[i], exp_k2);
      end
    end

    // Line below the picture bottom: entire line black.
    video_y = 16;
    clear_caps();
    for (int x = 0; x < 16; x++) begin
      y_data = {$urandom, $urandom}; u_data = {$urandom, $urandom};
      drive_px(1, x);
    end
    idle(D + 4);
    nblack = 0;
    foreach (cap_c0[i])
      if (cap_c0[i] == exp_k0 && cap_c1[i] == exp_k1 && cap_c2[i] == exp_k2) nblack++;
    chk("below_pic_black", nblack, 16);
    video_y = 0;

    // 44-cycle hsync pulse: delayed by the pipeline depth minus one.
    cyc0 = cyc; fall = -1; rise = -1;
    video_hs_n = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 44) video_hs_n = 1'b1;
      drive_px(0, 0);
      if (!out_hs_n && fall < 0) fall = cyc;
      if (out_hs_n && fall >= 0 && rise < 0) rise = cyc;
    end
    chk("hs_delay", fall - cyc0, D + 1);
    chk("hs_width", rise - fall, 44);

    // Reset in the middle of a line at x = 5.
    pic_width_in_mbs = 2;
    video_hs_n = 1'b0; video_vs_n = 1'b0;
    for (int x = 0; x < 6; x++) begin
      y_data = {$urandom, $urandom}; u_data = {$urandom, $urandom}; v_data = {$urandom, $urandom};
      drive_px(1, x);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_de", int'(out_de), 0);
    chk("midrst_c0", int'(pix_c0), 0);
    chk("midrst_c1", int'(pix_c1), 0);
    chk("midrst_c2", int'(pix_c2), 0);
    chk("midrst_hs", int'(out_hs_n), 1);
    chk("midrst_vs", int'(out_vs_n), 1);
    @(negedge video_clk);
    rst_n = 1'b1;
    video_hs_n = 1'b1; video_vs_n = 1'b1;
    for (int x = 6; x < 32; x++) begin
      y_data = {$urandom, $urandom}; u_data = {$urandom, $urandom}; v_data = {$urandom, $urandom};
      drive_px(1, x);
    end
    idle(D + 4);

    // Random lines with gaps, random geometry and syncs.
    for (int ln = 0; ln < 24; ln++) begin
      int x, len;
      pic_width_in_mbs = 9'($urandom_range(1, 4));
      pic_height_in_map_units = 9'($urandom_range(1, 3));
      video_y = 13'($urandom_range(0, 63));
      len = $urandom_range(8, 80);
      x = 0;
      for (int c = 0; c < len + 16 && x < len; c++) begin
        y_data = {$urandom, $urandom}; u_data = {$urandom, $urandom}; v_data = {$urandom, $urandom};
        video_hs_n = ($urandom_range(0, 7) != 0);
        video_vs_n = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 7) != 0) begin
          drive_px(1, x);
          x++;
        end else begin
          drive_px(0, x);
        end
      end
      video_hs_n = 1'b1; video_vs_n = 1'b1;
      idle($urandom_range(3, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
